// File: rtl/ntt_pkg.sv
// Shared definitions for the NTT sequencer: default geometry and FSM encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ntt_pkg;

  localparam int N_DEF         = 256;
  localparam int DATA_W_DEF    = 32;
  localparam int ADDR_W_DEF    = 7;
  localparam int STAGES_DEF    = 8;
  localparam int STAGE_TMO_DEF = 1024;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_RUN    = 3'd2,
    ST_UNLOAD = 3'd3,
    ST_FLUSH  = 3'd4
  } state_t;

endpackage

// File: rtl/ntt_unload_buf.sv
// Unload read-pending tracker plus output register with a valid/ready interface.
// Latency: read issued in cycle t, out_valid/out_data presented from cycle t+2.
// Backpressure: no new read while one is pending or out_valid stalls, so at most 1 beat per 2 cycles.
module ntt_unload_buf #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic              rd_go,
  input  logic [DATA_W-1:0] rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  logic pend;

  // Issue only when the output slot is free (or freeing this cycle) and nothing is in flight.
  assign rd_go = en && !pend && (!out_valid || out_ready);

  // RAM data lands one cycle after the strobe; hold it until the host takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      pend <= rd_go;
      if (pend) begin
        out_data  <= rdata;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ntt_seq_ctrl.sv
// NTT top sequencer: host load into banks, stage run with watchdog, unload stream. Optional macro NTT_PERF_CNT_EN adds perf_cycles.
// Latency: load writes are combinational in the accepting cycle; done is registered, one cycle after the last handshake.
// Backpressure: in_ready only in LOAD; unload throttled by out_ready, at most 1 result per 2 cycles.
module ntt_seq_ctrl
  import ntt_pkg::*;
#(
  parameter int N         = N_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int STAGES    = STAGES_DEF,
  parameter int STAGE_TMO = STAGE_TMO_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_start,
  output logic              busy,
  output logic              done,
  output logic              err,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              host_sel,
  output logic              ld_we0,
  output logic              ld_we1,
  output logic [ADDR_W-1:0] ld_addr,
  output logic [DATA_W-1:0] ld_data,
  output logic              ul_pair,
  output logic              ul_re,
  output logic              ul_bank,
  output logic [ADDR_W-1:0] ul_addr,
  input  logic [DATA_W-1:0] ul_rdata,
  output logic              ag_start,
  input  logic              ag_stage_flag
`ifdef NTT_PERF_CNT_EN
  ,
  output logic [31:0]       perf_cycles
`endif
);

  localparam int CNT_W = $clog2(N) + 1;
  localparam int S_W   = $clog2(STAGES) + 1;
  localparam int W_W   = $clog2(STAGE_TMO) + 1;

  state_t           state;
  logic [CNT_W-1:0] k;
  logic [CNT_W-1:0] u;
  logic [S_W-1:0]   s;
  logic [W_W-1:0]   wdog;
  logic             flag_q;
  logic             wr;
  logic             rd_go;
  logic             toggle;
  logic             accept;

  assign wr      = (state == ST_LOAD) && in_valid;
  assign ld_we0  = wr && !k[0];
  assign ld_we1  = wr && k[0];
  assign ld_addr = wr ? ADDR_W'(k >> 1) : '0;
  assign ld_data = wr ? in_data : '0;

  assign toggle  = ag_stage_flag ^ flag_q;
  assign accept  = out_valid && out_ready;

  // Results live in the pair the final stage wrote, which alternates with stage parity.
  assign ul_pair = (state == ST_UNLOAD) ? 1'(STAGES % 2) : 1'b0;
  assign ul_re   = rd_go;
  assign ul_bank = rd_go && u[0];
  assign ul_addr = rd_go ? ADDR_W'(u >> 1) : '0;

  ntt_unload_buf #(
    .DATA_W (DATA_W)
  ) u_unload_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (state == ST_UNLOAD),
    .rd_go     (rd_go),
    .rdata     (ul_rdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  // Registered copy of the generator's stage flag; any difference marks a finished stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) flag_q <= 1'b0;
    else        flag_q <= ag_stage_flag;
  end

  // Main sequencer: state, counters and all registered control outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      in_ready <= 1'b0;
      host_sel <= 1'b1;
      ag_start <= 1'b0;
      k        <= '0;
      u        <= '0;
      s        <= '0;
      wdog     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_start) begin
            state    <= ST_LOAD;
            err      <= 1'b0;
            k        <= '0;
            busy     <= 1'b1;
            in_ready <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (in_valid) begin
            k <= k + 1'b1;
            if (k == CNT_W'(N - 1)) begin
              state    <= ST_RUN;
              in_ready <= 1'b0;
              host_sel <= 1'b0;
              ag_start <= 1'b1;
              s        <= '0;
              wdog     <= '0;
            end
          end
        end
        ST_RUN: begin
          if (toggle) begin
            s    <= s + 1'b1;
            wdog <= '0;
            if (s == S_W'(STAGES - 1)) begin
              state    <= ST_UNLOAD;
              ag_start <= 1'b0;
              host_sel <= 1'b1;
              u        <= '0;
            end
          end else if (wdog == W_W'(STAGE_TMO - 1)) begin
            // Generator stalled: abort the transform without a done pulse.
            state    <= ST_IDLE;
            err      <= 1'b1;
            busy     <= 1'b0;
            ag_start <= 1'b0;
            host_sel <= 1'b1;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        ST_UNLOAD: begin
          if (rd_go) begin
            u <= u + 1'b1;
            if (u == CNT_W'(N - 1)) state <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (accept) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef NTT_PERF_CNT_EN
  // Cycles spent outside IDLE since the last accepted start; held afterwards, saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cycles <= '0;
    end else if (state == ST_IDLE) begin
      if (cmd_start) perf_cycles <= '0;
    end else if (perf_cycles != '1) begin
      perf_cycles <= perf_cycles + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ntt_seq_ctrl.sv
// Directed bench for ntt_seq_ctrl: load, stage run, unload, watchdog, async reset, back-to-back.
// Latency: n/a (testbench).
// Backpressure: drives random and continuous out_ready.
module tb_ntt_seq_ctrl;

  localparam int N         = 256;
  localparam int ADDR_W    = 7;
  localparam int STAGES    = 8;
  localparam int STAGE_TMO = 1024;
  localparam int STAGE_LEN = 132;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cmd_start;
  logic              busy, done, err;
  logic              in_valid, in_ready;
  logic [31:0]       in_data;
  logic              out_valid, out_ready;
  logic [31:0]       out_data;
  logic              host_sel, ld_we0, ld_we1;
  logic [ADDR_W-1:0] ld_addr;
  logic [31:0]       ld_data;
  logic              ul_pair, ul_re, ul_bank;
  logic [ADDR_W-1:0] ul_addr;
  logic [31:0]       ul_rdata;
  logic              ag_start, ag_stage_flag;
`ifdef NTT_PERF_CNT_EN
  logic [31:0]       perf_cycles;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ntt_seq_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cmd_start     (cmd_start),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .host_sel      (host_sel),
    .ld_we0        (ld_we0),
    .ld_we1        (ld_we1),
    .ld_addr       (ld_addr),
    .ld_data       (ld_data),
    .ul_pair       (ul_pair),
    .ul_re         (ul_re),
    .ul_bank       (ul_bank),
    .ul_addr       (ul_addr),
    .ul_rdata      (ul_rdata),
    .ag_start      (ag_start),
    .ag_stage_flag (ag_stage_flag)
`ifdef NTT_PERF_CNT_EN
    ,
    .perf_cycles   (perf_cycles)
`endif
  );

  task automatic test_reset;
    rst_n = 1'b0; cmd_start = 1'b0; in_valid = 1'b0; in_data = '0;
    out_ready = 1'b0; ul_rdata = '0; ag_stage_flag = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0 ||
        host_sel !== 1'b1 || ag_start !== 1'b0 || ul_re !== 1'b0 || ul_pair !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: busy=%b done=%b err=%b in_ready=%b out_valid=%b host_sel=%b ag_start=%b ul_re=%b, want 0 0 0 0 0 1 0 0",
               busy, done, err, in_ready, out_valid, host_sel, ag_start, ul_re);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 32'h1234;
    #1;
    total++;
    if (in_ready !== 1'b0 || ld_we0 !== 1'b0 || ld_we1 !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL idle_in_valid: in_ready=%b we0=%b we1=%b busy=%b, want all 0", in_ready, ld_we0, ld_we1, busy);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_start;
    cmd_start = 1'b1;
    @(posedge clk); #1;
    cmd_start = 1'b0;
    total++;
    if (busy !== 1'b1 || in_ready !== 1'b1 || err !== 1'b0 || host_sel !== 1'b1) begin
      bad++;
      $display("FAIL start: busy=%b in_ready=%b err=%b host_sel=%b, want 1 1 0 1", busy, in_ready, err, host_sel);
    end
  endtask

  task automatic test_load(input bit toggle_v);
    int kk = 0;
    for (int t = 0; t < 4 * N && kk < N; t++) begin
      in_valid = toggle_v ? (t % 2 == 1) : 1'b1;
      in_data  = 32'(kk);
      #1;
      total++;
      if (ld_we0 !== (in_valid && (kk % 2 == 0)) || ld_we1 !== (in_valid && (kk % 2 == 1))) begin
        bad++;
        $display("FAIL load_we k=%0d: we0=%b we1=%b in_valid=%b", kk, ld_we0, ld_we1, in_valid);
      end
      if (in_valid) begin
        total++;
        if (ld_addr !== ADDR_W'(kk >> 1) || ld_data !== 32'(kk)) begin
          bad++;
          $display("FAIL load_addr k=%0d: addr=%0d data=%0d, want %0d %0d", kk, ld_addr, ld_data, kk >> 1, kk);
        end
        if (kk == N - 1) begin
          total++;
          if (ag_start !== 1'b0) begin
            bad++;
            $display("FAIL load_early_run: ag_start=%b during last write, want 0", ag_start);
          end
        end
      end
      @(posedge clk); #1;
      if (in_valid) kk++;
    end
    in_valid = 1'b0;
    total++;
    if (kk != N || ag_start !== 1'b1 || host_sel !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL run_entry: writes=%0d ag_start=%b host_sel=%b in_ready=%b busy=%b, want %0d 1 0 0 1",
               kk, ag_start, host_sel, in_ready, busy, N);
    end
  endtask

  // Model address generator: flips stage_flag every STAGE_LEN cycles of ag_start when alive.
  task automatic test_run(input int stop_at, input bit alive, output int c);
    c = 0;
    in_valid = 1'b1;
    #1;
    for (int t = 0; t < 3000; t++) begin
      if (!ag_start) break;
      c++;
      total++;
      if (in_ready !== 1'b0 || ld_we0 !== 1'b0 || ld_we1 !== 1'b0 || host_sel !== 1'b0) begin
        bad++;
        $display("FAIL run_ignore c=%0d: in_ready=%b we0=%b we1=%b host_sel=%b, want 0 0 0 0",
                 c, in_ready, ld_we0, ld_we1, host_sel);
      end
      if (stop_at != 0 && c == stop_at) break;
      if (alive && (c % STAGE_LEN == 0)) ag_stage_flag = ~ag_stage_flag;
      cmd_start = (c == 50);
      @(posedge clk); #1;
    end
    cmd_start = 1'b0;
    in_valid  = 1'b0;
  endtask

  task automatic test_run_stages;
    int c;
    test_run(0, 1'b1, c);
    total++;
    if (c != STAGES * STAGE_LEN || busy !== 1'b1 || host_sel !== 1'b1 || ul_pair !== 1'b0 || err !== 1'b0) begin
      bad++;
      $display("FAIL run_len: ag_start cycles=%0d busy=%b host_sel=%b ul_pair=%b err=%b, want %0d 1 1 0 0",
               c, busy, host_sel, ul_pair, err, STAGES * STAGE_LEN);
    end
  endtask

  // Bank model: word (addr, bank) holds C0DE0000 + 7*(2*addr+bank).
  task automatic test_unload(input int ready_pct);
    int       j = 0;
    int       dn = 0;
    int       idx;
    bit       last_re = 1'b0;
    logic [ADDR_W-1:0] last_addr = '0;
    logic     last_bank = 1'b0;
    bit       prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
    logic [31:0] exp_d;
    for (int t = 0; t < 6000; t++) begin
      if (last_re) begin
        idx = int'(last_addr) * 2 + int'(last_bank);
        ul_rdata = 32'hC0DE_0000 + idx * 7;
      end else begin
        ul_rdata = 32'hDEAD_BEEF;
      end
      out_ready = ($urandom_range(0, 99) < ready_pct);
      #1;
      if (done) dn++;
      if (prev_stall) begin
        total++;
        if (out_valid !== 1'b1 || out_data !== prev_data) begin
          bad++;
          $display("FAIL stall_hold beat=%0d: valid=%b data=%h, want 1 %h", j, out_valid, out_data, prev_data);
        end
      end
      if (out_valid && out_ready) begin
        exp_d = 32'hC0DE_0000 + j * 7;
        total++;
        if (out_data !== exp_d) begin
          bad++;
          $display("FAIL order beat=%0d: data=%h, want %h", j, out_data, exp_d);
        end
        j++;
      end
      if (ul_re) begin
        total++;
        if (ul_pair !== 1'b0) begin
          bad++;
          $display("FAIL ul_pair: got %b, want 0", ul_pair);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      last_re    = ul_re;
      last_addr  = ul_addr;
      last_bank  = ul_bank;
      @(posedge clk); #1;
      if (j == N) break;
    end
    out_ready = 1'b0;
    total++;
    if (j != N || done !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL unload_end: beats=%0d done=%b busy=%b, want %0d 1 0", j, done, busy, N);
    end
    if (done) dn++;
`ifdef NTT_PERF_CNT_EN
    if (ready_pct >= 100) begin
      total++;
      if (perf_cycles !== 32'd1825) begin
        bad++;
        $display("FAIL perf_cycles: got %0d, want 1825", perf_cycles);
      end
    end
`endif
    @(posedge clk); #1;
    if (done) dn++;
    total++;
    if (dn != 1) begin
      bad++;
      $display("FAIL done_pulses: got %0d, want 1", dn);
    end
  endtask

  task automatic test_watchdog;
    int c;
    do_start();
    test_load(1'b0);
    test_run(0, 1'b0, c);
    total++;
    if (c != STAGE_TMO || err !== 1'b1 || busy !== 1'b0 || ag_start !== 1'b0 || host_sel !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("FAIL watchdog: cycles=%0d err=%b busy=%b ag_start=%b host_sel=%b done=%b, want %0d 1 0 0 1 0",
               c, err, busy, ag_start, host_sel, done, STAGE_TMO);
    end
    @(posedge clk); #1;
    total++;
    if (done !== 1'b0 || err !== 1'b1) begin
      bad++;
      $display("FAIL watchdog_hold: done=%b err=%b, want 0 1", done, err);
    end
  endtask

  task automatic test_reset_mid_run;
    int c;
    do_start();
    test_load(1'b0);
    test_run(3 * STAGE_LEN + 20, 1'b1, c);
    #3;
    rst_n = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || ag_start !== 1'b0 || host_sel !== 1'b1 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_run: busy=%b ag_start=%b host_sel=%b in_ready=%b, want 0 0 1 0",
               busy, ag_start, host_sel, in_ready);
    end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    do_start();
    test_load(1'b0);
    test_run_stages();
    test_unload(100);
  endtask

  initial begin
    test_reset();
    do_start();
    test_load(1'b1);
    test_run_stages();
    test_unload(30);
    test_watchdog();
    test_reset_mid_run();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
